aes_inv_cipher_seq: RTL

AES_INV_CIPHER_SEQ -- requirements
Module: aes_inv_cipher_seq

---
 rtl/aes_inv_cipher_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_seq.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_cipher_seq
//  Purpose  : Sequencer for AES-128 decryption on a shared, externally
//             supplied transform datapath. It walks the fixed 40-step
//             inverse-cipher schedule and launches one transform at a time.
//             Each transform result is written back into the working
//             register, and the plaintext is presented when the schedule
//             is complete.
//  Ports    :
//     clk_in       in   1    clock; all state changes on its rising edge
//     rst_in       in   1    synchronous active-high reset
//     start        in   1    new ciphertext block present on block_in
//     block_in     in   128  ciphertext block
//     step_start   out  1    one-cycle launch pulse for the datapath
//     step_sel     out  2    0 ADD_ROUND_KEY, 1 INV_SHIFT_ROWS,
//                            2 INV_SUB_BYTES, 3 INV_MIX_COLUMNS
//     step_block   out  128  operand for the launched transform
//     key_idx      out  4    round-key index (0..10)
//     step_result  in   128  transform result
//     step_valid   in   1    step_result valid in this cycle
//     result_out   out  128  plaintext, held until the next result or reset
//     valid_out    out  1    one-cycle pulse with a new plaintext
//     busy         out  1    high whenever the FSM is not idle
//  Revision : 1.0  initial release
// ============================================================================
module aes_inv_cipher_seq (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         start,
   input  logic [127:0] block_in,
   output logic         step_start,
   output logic [1:0]   step_sel,
   output logic [127:0] step_block,
   output logic [3:0]   key_idx,
   input  logic [127:0] step_result,
   input  logic         step_valid,
   output logic [127:0] result_out,
   output logic         valid_out,
   output logic         busy
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_issue  = 2'd1;
   localparam logic [1:0] c_st_wait   = 2'd2;
   localparam logic [1:0] c_st_output = 2'd3;

   localparam logic [1:0] c_sel_ark = 2'd0;
   localparam logic [1:0] c_sel_isr = 2'd1;
   localparam logic [1:0] c_sel_isb = 2'd2;
   localparam logic [1:0] c_sel_imc = 2'd3;

   localparam logic [5:0] c_last_step = 6'd39;
   localparam logic [3:0] c_top_key   = 4'd10;
   localparam logic [3:0] c_nine      = 4'd9;

   logic [1:0]   r_state;
   logic [1:0]   w_next_state;
   logic [127:0] r_work;
   logic [5:0]   r_cnt;
   logic [127:0] r_result;

   logic         w_accept;
   logic         w_last;
   logic         w_active;
   logic [5:0]   w_j;
   logic [1:0]   w_sel;
   logic [3:0]   w_key;

   assign w_accept = (r_state == c_st_wait) && step_valid;
   assign w_last   = (r_cnt == c_last_step);

   // ------------------------------------------------------------------------
   // Schedule decode. Step 0 is the initial key-10 whitening. Every later
   // step s maps to j = s-1: j[1:0] is the position inside a round
   // (shift, sub, add-key, mix) and j[5:2] counts rounds from key 9 down.
   // The final partial round (steps 37..39) falls out of the same formula
   // with key 0; its mix phase is never reached because step 39 is last.
   // ------------------------------------------------------------------------
   assign w_j = r_cnt - 6'd1;

   always_comb begin
      w_sel = c_sel_ark;
      w_key = c_top_key;
      if (r_cnt != 6'd0) begin
         w_key = c_nine - w_j[5:2];
         case (w_j[1:0])
            2'd0:    w_sel = c_sel_isr;
            2'd1:    w_sel = c_sel_isb;
            2'd2:    w_sel = c_sel_ark;
            default: w_sel = c_sel_imc;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle:   if (start) w_next_state = c_st_issue;
         c_st_issue:  w_next_state = c_st_wait;
         c_st_wait:   if (step_valid) w_next_state = w_last ? c_st_output : c_st_issue;
         c_st_output: w_next_state = c_st_idle;
         default:     w_next_state = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. The step descriptors are only exposed while a step is
   // in flight, so they read as zero when idle or just out of reset. They
   // depend only on r_cnt and r_work, which change solely on an accepted
   // step_valid, so they hold steady from launch to acceptance.
   // ------------------------------------------------------------------------
   always_comb begin
      w_active   = (r_state == c_st_issue) || (r_state == c_st_wait);
      step_start = (r_state == c_st_issue);
      valid_out  = (r_state == c_st_output);
      busy       = (r_state != c_st_idle);
      step_sel   = w_active ? w_sel  : 2'd0;
      key_idx    = w_active ? w_key  : 4'd0;
      step_block = w_active ? r_work : 128'd0;
   end

   assign result_out = r_result;

   // ------------------------------------------------------------------------
   // Working register, step counter and result holding register. The
   // result register is loaded together with the final step so that it is
   // already valid during the single OUTPUT cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_work   <= 128'd0;
         r_cnt    <= 6'd0;
         r_result <= 128'd0;
      end else if ((r_state == c_st_idle) && start) begin
         r_work <= block_in;
         r_cnt  <= 6'd0;
      end else if (w_accept) begin
         r_work <= step_result;
         r_cnt  <= r_cnt + 6'd1;
         if (w_last) begin
            r_result <= step_result;
         end
      end
   end

endmodule
`default_nettype wire
